// File: rtl/rv_pkg.sv
// rv_pkg: RV32I/RV64I opcode constants and operand-usage helpers shared by
// decode and the ID/EX stage.
//   uses_rs1(op)  : instruction reads rs1
//   uses_rs2(op)  : instruction reads rs2
//   writes_rd(op) : instruction writes rd
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OPC_JALR)  || (op == OPC_BRANCH) || (op == OPC_LOAD) ||
           (op == OPC_STORE) || (op == OPC_OPIMM)  || (op == OPC_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_STORE) || (op == OPC_OP);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OPC_LUI)  || (op == OPC_AUIPC) || (op == OPC_JAL)   ||
           (op == OPC_JALR) || (op == OPC_LOAD)  || (op == OPC_OPIMM) ||
           (op == OPC_OP);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: one source-operand bypass mux with hazard flag.
//   i_use            : operand is read by a valid ID instruction
//   i_rs             : source register index
//   i_{ex,me,wb}_wr  : stage holds a valid instruction that writes rd
//   i_{ex,me,wb}_rd  : destination register of that stage
//   i_{ex,me,wb}_data: value that stage would forward
//   i_rf_data        : register-file read data (fallback)
//   o_data           : selected operand, priority EX > ME > WB > RF
//   o_hazard         : a producer matches in a stage whose bypass is disabled
module fwd_sel #(
  parameter int XLEN   = 32,
  parameter bit FWD_EX = 1'b1,
  parameter bit FWD_ME = 1'b1,
  parameter bit FWD_WB = 1'b1
) (
  input  logic            i_use,
  input  logic [4:0]      i_rs,
  input  logic            i_ex_wr,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_data,
  input  logic            i_me_wr,
  input  logic [4:0]      i_me_rd,
  input  logic [XLEN-1:0] i_me_data,
  input  logic            i_wb_wr,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_rf_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_hazard
);

  logic w_chk, w_ex_hit, w_me_hit, w_wb_hit;

  // x0 is hard-wired zero and never depends on a producer.
  assign w_chk    = i_use && (i_rs != 5'd0);
  assign w_ex_hit = w_chk && i_ex_wr && (i_ex_rd == i_rs);
  assign w_me_hit = w_chk && i_me_wr && (i_me_rd == i_rs);
  assign w_wb_hit = w_chk && i_wb_wr && (i_wb_rd == i_rs);

  always_comb begin
    o_data = i_rf_data;
    if (w_ex_hit && FWD_EX)      o_data = i_ex_data;
    else if (w_me_hit && FWD_ME) o_data = i_me_data;
    else if (w_wb_hit && FWD_WB) o_data = i_wb_data;
  end

  // Any match in a non-bypassed stage must wait for that producer to retire.
  assign o_hazard = (w_ex_hit && !FWD_EX) || (w_me_hit && !FWD_ME) ||
                    (w_wb_hit && !FWD_WB);

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with operand forwarding, hazard stall
// and a multi-cycle load-use stall FSM.
//   clock, reset       : rising-edge clock, async active-high reset
//   id_*               : decode-side instruction, operands, handshake
//   flush              : kill captured and incoming instruction
//   ex_ready           : EX consumes out_* this cycle
//   ex_*, me_*, wb_*   : producer info from later stages for bypass/hazards
//   out_*              : registered instruction and operands toward EX
//   stall              : hazard stall active
module id_ex_pipe
  import rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit FWD_EX     = 1'b1,
  parameter bit FWD_ME     = 1'b1,
  parameter bit FWD_WB     = 1'b1,
  parameter int LOAD_STALL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_valid,
  input  logic [31:0]     ex_instr,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic            me_valid,
  input  logic            me_wb_en,
  input  logic [4:0]      me_rd,
  input  logic [XLEN-1:0] me_data,
  input  logic            wb_wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            stall
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LU    = 1'b1;
  localparam logic [2:0] LS_INIT = 3'(LOAD_STALL - 1);

  logic [0:0]      r_state;
  logic [2:0]      r_cnt;
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
  logic [31:0]     r_instr;

  logic [6:0]      w_id_op, w_ex_op;
  logic [4:0]      w_rs1, w_rs2, w_ex_rd;
  logic            w_use1, w_use2;
  logic            w_ex_load, w_ex_wr, w_me_wr, w_wb_wr;
  logic            w_lu_det, w_haz1, w_haz2, w_hazard, w_stall, w_accept;
  logic [XLEN-1:0] w_op1, w_op2;

  assign w_id_op = id_instr[6:0];
  assign w_rs1   = id_instr[19:15];
  assign w_rs2   = id_instr[24:20];
  assign w_use1  = id_valid && uses_rs1(w_id_op);
  assign w_use2  = id_valid && uses_rs2(w_id_op);

  assign w_ex_op   = ex_instr[6:0];
  assign w_ex_rd   = ex_instr[11:7];
  assign w_ex_load = ex_valid && (w_ex_op == OPC_LOAD);
  // A load's ex_alu_res is its address, so loads are excluded from EX bypass
  // and handled by the load-use FSM instead.
  assign w_ex_wr   = ex_valid && writes_rd(w_ex_op) && !w_ex_load;
  assign w_me_wr   = me_valid && me_wb_en;
  assign w_wb_wr   = wb_wb_en;

  assign w_lu_det = w_ex_load && (w_ex_rd != 5'd0) &&
                    ((w_use1 && (w_rs1 == w_ex_rd)) ||
                     (w_use2 && (w_rs2 == w_ex_rd)));

  fwd_sel #(.XLEN(XLEN), .FWD_EX(FWD_EX), .FWD_ME(FWD_ME), .FWD_WB(FWD_WB))
  u_fwd_rs1 (
    .i_use(w_use1), .i_rs(w_rs1),
    .i_ex_wr(w_ex_wr), .i_ex_rd(w_ex_rd), .i_ex_data(ex_alu_res),
    .i_me_wr(w_me_wr), .i_me_rd(me_rd),   .i_me_data(me_data),
    .i_wb_wr(w_wb_wr), .i_wb_rd(wb_rd),   .i_wb_data(wb_data),
    .i_rf_data(id_rs1_val), .o_data(w_op1), .o_hazard(w_haz1)
  );

  fwd_sel #(.XLEN(XLEN), .FWD_EX(FWD_EX), .FWD_ME(FWD_ME), .FWD_WB(FWD_WB))
  u_fwd_rs2 (
    .i_use(w_use2), .i_rs(w_rs2),
    .i_ex_wr(w_ex_wr), .i_ex_rd(w_ex_rd), .i_ex_data(ex_alu_res),
    .i_me_wr(w_me_wr), .i_me_rd(me_rd),   .i_me_data(me_data),
    .i_wb_wr(w_wb_wr), .i_wb_rd(wb_rd),   .i_wb_data(wb_data),
    .i_rf_data(id_rs2_val), .o_data(w_op2), .o_hazard(w_haz2)
  );

  assign w_hazard = w_haz1 || w_haz2 || w_lu_det;
  // Gated by reset so stall/id_ready read 0 while reset is held.
  assign w_stall  = !reset && (w_hazard || (r_state == S_LU));
  assign id_ready = !reset && !w_stall && !flush && (!r_valid || ex_ready);
  assign w_accept = id_valid && id_ready;

  // The detect cycle stalls combinationally; LU then holds for LOAD_STALL
  // more cycles, each counted only when EX takes the bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_lu_det) begin
          r_state <= S_LU;
          r_cnt   <= LS_INIT;
        end
        S_LU: if (ex_ready) begin
          if (r_cnt == 3'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (r_valid && !ex_ready) begin
      r_valid <= r_valid;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= id_pc;
      r_instr <= id_instr;
      r_rs1   <= w_op1;
      r_rs2   <= w_op2;
      r_imm   <= id_imm;
    end else begin
      r_valid <= 1'b0;
      r_instr <= '0;
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign out_instr = r_instr;
  assign out_rs1   = r_rs1;
  assign out_rs2   = r_rs2;
  assign out_imm   = r_imm;
  assign stall     = w_stall;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed scoreboard bench for id_ex_pipe
// (XLEN=64, FWD_EX=1, FWD_ME=1, FWD_WB=0, LOAD_STALL=2).
module tb_id_ex_pipe;
  import rv_pkg::*;

  logic        clock, reset, id_valid, id_ready, flush, ex_ready, ex_valid;
  logic        me_valid, me_wb_en, wb_wb_en, out_valid, stall;
  logic [63:0] id_pc, id_rs1_val, id_rs2_val, id_imm, ex_alu_res, me_data, wb_data;
  logic [63:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [31:0] id_instr, ex_instr, out_instr;
  logic [4:0]  me_rd, wb_rd;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rs1, rs2, imm;
  } out_t;

  out_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  id_ex_pipe #(.XLEN(64), .FWD_EX(1'b1), .FWD_ME(1'b1), .FWD_WB(1'b0),
               .LOAD_STALL(2)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_alu_res(ex_alu_res), .me_valid(me_valid), .me_wb_en(me_wb_en),
    .me_rd(me_rd), .me_data(me_data), .wb_wb_en(wb_wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] f_i(input logic [6:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rd, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_pc = '0; id_instr = '0; id_rs1_val = '0; id_rs2_val = '0;
    id_imm = '0; flush = 0; ex_ready = 1; ex_valid = 0; ex_instr = '0;
    ex_alu_res = '0; me_valid = 0; me_wb_en = 0; me_rd = '0; me_data = '0;
    wb_wb_en = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [31:0] ins,
                       input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] imm);
    id_valid = 1; id_pc = pc; id_instr = ins;
    id_rs1_val = r1; id_rs2_val = r2; id_imm = imm;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] ins,
                      input logic [63:0] r1, input logic [63:0] r2,
                      input logic [63:0] imm);
    out_t e;
    e.pc = pc; e.instr = ins; e.rs1 = r1; e.rs2 = r2; e.imm = imm;
    q.push_back(e);
  endtask

  // Monitor: every cycle EX consumes a valid output, pop and compare.
  initial begin
    out_t e, a;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && ex_ready) begin
        a = {out_pc, out_instr, out_rs1, out_rs2, out_imm};
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_out: got pc=%h instr=%h with nothing expected",
                   out_pc, out_instr);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            n_miss++;
            $display("FAIL out_vec: got pc=%h ins=%h rs1=%h rs2=%h imm=%h expected pc=%h ins=%h rs1=%h rs2=%h imm=%h",
                     a.pc, a.instr, a.rs1, a.rs2, a.imm, e.pc, e.instr, e.rs1, e.rs2, e.imm);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] i_sub, i_add, i_lw, i_st, i_lui;
    clr();
    reset = 1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_rs1",   out_rs1, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    tick(); tick();
    reset = 0;

    // EX forward: SUB x8,x5,x9 with ADD x5 in EX
    i_sub = f_r(7'h20, 5'd9, 5'd5, 5'd8);
    issue(64'h100, i_sub, 64'hAAAA, 64'h22, 64'h7);
    ex_valid = 1; ex_instr = f_r(7'h00, 5'd2, 5'd1, 5'd5);
    ex_alu_res = 64'h1234_5678_9ABC_0011;
    #1;
    chk("ex_fwd_stall", 64'(stall), 64'd0);
    chk("ex_fwd_ready", 64'(id_ready), 64'd1);
    push(64'h100, i_sub, 64'h1234_5678_9ABC_0011, 64'h22, 64'h7);
    tick();

    // EX beats ME on rs1; rs2 from register file
    clr();
    i_add = f_r(7'h00, 5'd4, 5'd3, 5'd10);
    issue(64'h104, i_add, 64'h1, 64'h55, 64'h0);
    ex_valid = 1; ex_instr = f_r(7'h00, 5'd2, 5'd1, 5'd3); ex_alu_res = 64'h33;
    me_valid = 1; me_wb_en = 1; me_rd = 5'd3; me_data = 64'h44;
    push(64'h104, i_add, 64'h33, 64'h55, 64'h0);
    tick();

    // ME only
    clr();
    i_add = f_r(7'h00, 5'd0, 5'd3, 5'd11);
    issue(64'h108, i_add, 64'h1, 64'h0, 64'h0);
    me_valid = 1; me_wb_en = 1; me_rd = 5'd3; me_data = 64'h44;
    push(64'h108, i_add, 64'h44, 64'h0, 64'h0);
    tick();

    // STORE in EX does not write rd even though bits[11:7] match
    clr();
    i_add = f_r(7'h00, 5'd0, 5'd5, 5'd17);
    issue(64'h10C, i_add, 64'h5151, 64'h0, 64'h0);
    i_st = {7'd0, 5'd2, 5'd1, 3'b010, 5'd5, OPC_STORE};
    ex_valid = 1; ex_instr = i_st; ex_alu_res = 64'hBEEF;
    push(64'h10C, i_add, 64'h5151, 64'h0, 64'h0);
    tick();

    // LUI does not read rs1: a load to the matching field must not stall
    clr();
    i_lui = {12'h000, 5'd6, 3'b000, 5'd18, OPC_LUI};
    issue(64'h110, i_lui, 64'h61, 64'h62, 64'h6000);
    ex_valid = 1; ex_instr = f_i(OPC_LOAD, 5'd1, 5'd6, 12'h0);
    #1;
    chk("lui_no_stall", 64'(stall), 64'd0);
    push(64'h110, i_lui, 64'h61, 64'h62, 64'h6000);
    tick();

    // Load-use, LOAD_STALL=2: detect cycle + two LU cycles
    clr();
    i_add = f_r(7'h00, 5'd6, 5'd1, 5'd12);
    i_lw  = f_i(OPC_LOAD, 5'd1, 5'd6, 12'h0);
    issue(64'h200, i_add, 64'h10, 64'hDEAD, 64'h0);
    ex_valid = 1; ex_instr = i_lw; ex_alu_res = 64'h999;
    #1;
    chk("lu_det_stall", 64'(stall), 64'd1);
    chk("lu_det_ready", 64'(id_ready), 64'd0);
    tick();
    ex_valid = 0;
    #1;
    chk("lu1_ready",  64'(id_ready), 64'd0);
    chk("lu1_bubble", 64'(out_valid), 64'd0);
    chk("lu1_nop",    64'(out_instr), 64'd0);
    tick();
    #1;
    chk("lu2_stall",  64'(stall), 64'd1);
    chk("lu2_bubble", 64'(out_valid), 64'd0);
    tick();
    me_valid = 1; me_wb_en = 1; me_rd = 5'd6; me_data = 64'hCAFE;
    #1;
    chk("lu_done_ready", 64'(id_ready), 64'd1);
    push(64'h200, i_add, 64'h10, 64'hCAFE, 64'h0);
    tick();

    // FWD_WB=0: WB producer stalls until it drops
    clr();
    i_add = f_i(OPC_OPIMM, 5'd7, 5'd13, 12'h003);
    issue(64'h300, i_add, 64'h77, 64'h0, 64'h3);
    wb_wb_en = 1; wb_rd = 5'd7; wb_data = 64'hBAD;
    #1;
    chk("wb_haz_stall", 64'(stall), 64'd1);
    chk("wb_haz_ready", 64'(id_ready), 64'd0);
    tick();
    #1;
    chk("wb_haz_stall2", 64'(stall), 64'd1);
    tick();
    wb_wb_en = 0;
    #1;
    chk("wb_clear_stall", 64'(stall), 64'd0);
    push(64'h300, i_add, 64'h77, 64'h0, 64'h3);
    tick();

    // Backpressure: hold for 3 cycles
    clr();
    i_add = f_r(7'h00, 5'd2, 5'd1, 5'd14);
    issue(64'h400, i_add, 64'h1, 64'h2, 64'h0);
    push(64'h400, i_add, 64'h1, 64'h2, 64'h0);
    tick();
    issue(64'h404, i_add, 64'h3, 64'h4, 64'h0);
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(id_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc",    out_pc, 64'h400);
      chk("bp_rs2",   out_rs2, 64'h2);
      tick();
    end
    ex_ready = 1;
    #1;
    chk("bp_release_ready", 64'(id_ready), 64'd1);
    push(64'h404, i_add, 64'h3, 64'h4, 64'h0);
    tick();

    // Flush kills a held output; other fields keep their values
    clr();
    issue(64'h500, i_add, 64'h5, 64'h6, 64'h0);
    tick();
    clr();
    ex_ready = 0; flush = 1;
    tick();
    flush = 0; ex_ready = 1;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc_kept", out_pc, 64'h500);
    tick();

    // Flush together with load-use detect leaves FSM idle
    i_add = f_r(7'h00, 5'd0, 5'd6, 5'd19);
    issue(64'h520, i_add, 64'h9, 64'h0, 64'h0);
    ex_valid = 1; ex_instr = i_lw; flush = 1;
    #1;
    chk("fd_ready", 64'(id_ready), 64'd0);
    tick();
    flush = 0; ex_valid = 0;
    #1;
    chk("fd_idle_stall", 64'(stall), 64'd0);
    push(64'h520, i_add, 64'h9, 64'h0, 64'h0);
    tick();

    // Flush during LU with cnt=1
    issue(64'h540, i_add, 64'hA, 64'h0, 64'h0);
    ex_valid = 1; ex_instr = i_lw;
    tick();
    ex_valid = 0; flush = 1;
    #1;
    chk("flu_stall", 64'(stall), 64'd1);
    tick();
    flush = 0;
    #1;
    chk("flu_valid", 64'(out_valid), 64'd0);
    chk("flu_stall_idle", 64'(stall), 64'd0);
    chk("flu_ready", 64'(id_ready), 64'd1);
    push(64'h540, i_add, 64'hA, 64'h0, 64'h0);
    tick();

    // x0 never forwards nor hazards
    clr();
    i_add = f_r(7'h00, 5'd0, 5'd0, 5'd15);
    issue(64'h580, i_add, 64'h0, 64'h0, 64'h0);
    ex_valid = 1; ex_instr = f_i(OPC_OPIMM, 5'd1, 5'd0, 12'h1); ex_alu_res = 64'h1234;
    me_valid = 1; me_wb_en = 1; me_rd = 5'd0; me_data = 64'h5;
    wb_wb_en = 1; wb_rd = 5'd0; wb_data = 64'h6;
    #1;
    chk("x0_stall", 64'(stall), 64'd0);
    push(64'h580, i_add, 64'h0, 64'h0, 64'h0);
    tick();

    // Async reset mid-LU with held output
    clr();
    issue(64'h600, i_add, 64'hF00D, 64'h0, 64'h0);
    tick();
    i_add = f_r(7'h00, 5'd0, 5'd6, 5'd16);
    issue(64'h604, i_add, 64'h7, 64'h0, 64'h0);
    ex_valid = 1; ex_instr = i_lw; ex_ready = 0;
    tick();
    ex_valid = 0;
    #1;
    chk("pre_rst_pc", out_pc, 64'h600);
    #2;
    reset = 1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pc",    out_pc, 64'd0);
    chk("arst_instr", 64'(out_instr), 64'd0);
    chk("arst_rs1",   out_rs1, 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    tick();
    reset = 0; ex_ready = 1;
    #1;
    chk("post_rst_stall", 64'(stall), 64'd0);
    chk("post_rst_ready", 64'(id_ready), 64'd1);
    push(64'h604, i_add, 64'h7, 64'h0, 64'h0);
    tick();

    clr();
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    tick();
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d outstanding expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
